matrix_multiply_sequencer: RTL
==============================

// Module: matrix_multiply_sequencer
// PURPOSE
//  Control sequencer for rectangular matrix multiply C[MxN] = A[MxK] * B[KxN].
//  Walks row/col/inner indices with P-wide inner steps, drives MAC clear/enable,
//  flushes the datapath pipeline, then streams results out via a valid/ready handshake.
//  Sits between the host start/abort interface and the matrix_multiply datapath/RAMs.
// PARAMETERS
//  ROWS_A               2  M: rows of A and C
//  INNER_DIM           16  K: cols of A / rows of B; must be a multiple of P
//  COLS_B               2  N: cols of B and C
//  NUM_PARALLEL_OUTPUTS 1  P: inner-dimension elements consumed per beat
//  DRAIN_CYCLES         2  datapath latency flushed after last beat (>=0)
//  Derived widths: KW/MW/NW/OW = max(1,$clog2(K / M / N / M*N))
// PORTS
//  clk          in   1   clock, rising edge
//  resetn       in   1   asynchronous active-low reset
//  start        in   1   1-cycle request to begin; honoured only in IDLE
//  abort        in   1   return to IDLE from any state next cycle
//  k_select     out  KW  inner index of current beat (steps by P)
//  row_select   out  MW  current row i of A
//  col_select   out  NW  current column j of B
//  mac_clear    out  1   first beat of a dot product (k_select==0)
//  mac_en       out  1   beat valid for datapath
//  col_done     out  1   1-cycle pulse, cycle after last beat of each dot product
//  busy         out  1   high in COMPUTE and DRAIN
//  done         out  1   1-cycle pulse on entry to RESULT
//  out_valid    out  1   result element available (RESULT state)
//  out_ready    in   1   consumer accepts element when out_valid&&out_ready
//  out_index    out  OW  row-major index i*N+j of presented element
//  out_last     out  1   out_valid && out_index==M*N-1
//  read_done    out  1   1-cycle pulse after last element accepted
//  start_err    out  1   1-cycle pulse: start seen while not IDLE
//  perf_cycles  out  32  compute+drain cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all selects/indices 0; every 1-bit output 0; perf_cycles 0.
//  FSM IDLE -> COMPUTE -> DRAIN -> RESULT -> IDLE; abort overrides all (-> IDLE).
//  IDLE: start=1 -> COMPUTE next cycle, k/i/j cleared. busy and mac_en rise same edge.
//  COMPUTE: mac_en=1 every cycle; k += P; at k==K-P: k->0, j++; at j==N-1 wrap: j->0, i++.
//   Beat order row-major over (i,j), inner k fastest. Total beats M*N*K/P.
//   Beat (i=M-1,j=N-1,k=K-P) is last -> DRAIN (or RESULT if DRAIN_CYCLES=0).
//  col_done: registered, high the cycle after each beat with k==K-P (incl. last).
//  DRAIN: mac_en=0, busy=1, count DRAIN_CYCLES cycles -> RESULT.
//  RESULT: busy=0; done=1 first cycle only; out_valid=1 continuously.
//   out_index increments on each out_valid&&out_ready; holds otherwise.
//   Accept with out_last -> IDLE, read_done pulses next cycle, out_index->0.
//  start while COMPUTE/DRAIN/RESULT: ignored, start_err pulses next cycle.
//  start and abort same cycle: abort wins; start ignored, no start_err.
//  abort: next cycle IDLE, counters 0, no done/read_done/col_done pulse generated.
//  Arithmetic: counters wrap by explicit compare, never by width overflow;
//   out_index computed as counter, not multiply. Selects hold value outside COMPUTE.
// CONFIGURATION
//  MATMUL_SEQ_PERF_EN defined: 32-bit counter cleared on accepted start,
//   increments each cycle in COMPUTE or DRAIN, saturates at 2^32-1, holds in
//   RESULT/IDLE until next accepted start; abort clears it.
//  Not defined: counter not built, perf_cycles tied to 0.
// TESTING  (M=2,K=4,N=3,P=2,DRAIN_CYCLES=2 unless noted)
//  start pulse at edge 0 -> mac_en cycles 1..12, 6 col_done pulses, done in cycle 15.
//  RESULT with out_ready=1 -> out_index 0..5, out_last at 5, read_done 1 cycle later.
//  out_ready toggling 1,0,1,0 -> out_index advances only on ready cycles, no skip/dup.
//  start during COMPUTE (cycle 5) -> start_err pulse, beat sequence unchanged.
//  abort at cycle 7 -> IDLE cycle 8, no done; new start completes normally.
//  PERF_EN, full run -> perf_cycles==14; async resetn low mid-RESULT -> all outputs 0.

Source files
------------

// File: rtl/matrix_multiply_sequencer.sv
// Control sequencer for C[MxN] = A[MxK] * B[KxN].
// Walks (row, col, inner) indices with P-wide inner beats, drives MAC clear/enable,
// flushes the datapath pipeline, then streams result indices out via valid/ready.
// Optional feature: define MATMUL_SEQ_PERF_EN to build the 32-bit compute+drain cycle counter.
module matrix_multiply_sequencer #(
    parameter int ROWS_A               = 2,
    parameter int INNER_DIM            = 16,
    parameter int COLS_B               = 2,
    parameter int NUM_PARALLEL_OUTPUTS = 1,
    parameter int DRAIN_CYCLES         = 2,
    localparam int KW = (INNER_DIM > 1) ? $clog2(INNER_DIM) : 1,
    localparam int MW = (ROWS_A > 1) ? $clog2(ROWS_A) : 1,
    localparam int NW = (COLS_B > 1) ? $clog2(COLS_B) : 1,
    localparam int OW = (ROWS_A * COLS_B > 1) ? $clog2(ROWS_A * COLS_B) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    output logic [KW-1:0] k_select,
    output logic [MW-1:0] row_select,
    output logic [NW-1:0] col_select,
    output logic          mac_clear,
    output logic          mac_en,
    output logic          col_done,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_index,
    output logic          out_last,
    output logic          read_done,
    output logic          start_err,
    output logic [31:0]   perf_cycles
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // Wrap points and step sizes, sized to the counters they are compared against
    localparam logic [KW-1:0] K_LAST = KW'(INNER_DIM - NUM_PARALLEL_OUTPUTS);
    localparam logic [KW-1:0] K_STEP = KW'(NUM_PARALLEL_OUTPUTS);
    localparam logic [MW-1:0] M_LAST = MW'(ROWS_A - 1);
    localparam logic [NW-1:0] N_LAST = NW'(COLS_B - 1);
    localparam logic [OW-1:0] O_LAST = OW'(ROWS_A * COLS_B - 1);
    localparam logic [DW-1:0] D_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [MW-1:0] i_q, i_d;
    logic [NW-1:0] j_q, j_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [OW-1:0] idx_q, idx_d;
    logic          col_done_q, col_done_d;
    logic          done_q, done_d;
    logic          read_done_q, read_done_d;
    logic          start_err_q, start_err_d;

    // Next-state, index walking and pulse generation; abort overrides everything last
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        i_d         = i_q;
        j_d         = j_q;
        drain_d     = drain_q;
        idx_d       = idx_q;
        col_done_d  = 1'b0;
        done_d      = 1'b0;
        read_done_d = 1'b0;
        start_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COMPUTE;
                    k_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    drain_d = '0;
                end
            end
            S_COMPUTE: begin
                if (k_q == K_LAST) begin
                    col_done_d = 1'b1;
                    if (j_q == N_LAST) begin
                        if (i_q == M_LAST) begin
                            // Final beat: selects keep the last beat's indices
                            state_d = (DRAIN_CYCLES == 0) ? S_RESULT : S_DRAIN;
                            drain_d = '0;
                        end else begin
                            k_d = '0;
                            j_d = '0;
                            i_d = i_q + MW'(1);
                        end
                    end else begin
                        k_d = '0;
                        j_d = j_q + NW'(1);
                    end
                end else begin
                    k_d = k_q + K_STEP;
                end
            end
            S_DRAIN: begin
                if (drain_q == D_LAST) begin
                    state_d = S_RESULT;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    if (idx_q == O_LAST) begin
                        state_d     = S_IDLE;
                        idx_d       = '0;
                        read_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + OW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start && (state_q != S_IDLE)) begin
            start_err_d = 1'b1;
        end

        done_d = (state_d == S_RESULT) && (state_q != S_RESULT);

        if (abort) begin
            state_d     = S_IDLE;
            k_d         = '0;
            i_d         = '0;
            j_d         = '0;
            drain_d     = '0;
            idx_d       = '0;
            col_done_d  = 1'b0;
            done_d      = 1'b0;
            read_done_d = 1'b0;
            start_err_d = 1'b0;
        end
    end

    // State, counters and registered pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            drain_q     <= '0;
            idx_q       <= '0;
            col_done_q  <= 1'b0;
            done_q      <= 1'b0;
            read_done_q <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            i_q         <= i_d;
            j_q         <= j_d;
            drain_q     <= drain_d;
            idx_q       <= idx_d;
            col_done_q  <= col_done_d;
            done_q      <= done_d;
            read_done_q <= read_done_d;
            start_err_q <= start_err_d;
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating compute+drain cycle counter, cleared on accepted start or abort
    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start) begin
            perf_d = '0;
        end else if (((state_q == S_COMPUTE) || (state_q == S_DRAIN)) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
        if (abort) begin
            perf_d = '0;
        end
    end

    // Performance counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

    assign k_select   = k_q;
    assign row_select = i_q;
    assign col_select = j_q;
    assign mac_en     = (state_q == S_COMPUTE);
    assign mac_clear  = mac_en && (k_q == '0);
    assign busy       = (state_q == S_COMPUTE) || (state_q == S_DRAIN);
    assign out_valid  = (state_q == S_RESULT);
    assign out_index  = idx_q;
    assign out_last   = out_valid && (idx_q == O_LAST);
    assign col_done   = col_done_q;
    assign done       = done_q;
    assign read_done  = read_done_q;
    assign start_err  = start_err_q;

endmodule
